load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sizes, aligns and sign-extends loads, read-modify-writes sub-word stores.
// Latency: error 1 cycle, load/word store 2, sub-word store 3; one request in flight, req_ready only when idle.
module load_store_unit #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_write_data_q, mem_write_data_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_error_q, resp_error_d;

  logic              req_err;
  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [31:0]       rd_shifted;
  logic [31:0]       merged;
  logic [31:0]       load_val;

  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    byte_sh    = {addr_lo_q, 3'b000};
    half_sh    = {addr_lo_q[1], 4'b0000};
    rd_shifted = mem_read_data >> byte_sh;

    // Read-modify-write: only the addressed lanes take store data.
    merged = mem_read_data;
    if (size_q == 2'b00) merged[byte_sh +: 8] = wdata_q[7:0];
    else                 merged[half_sh +: 16] = wdata_q;

    case (size_q)
      2'b00:   load_val = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    signed_d         = signed_q;
    addr_lo_d        = addr_lo_q;
    wdata_d          = wdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    resp_rdata_d     = resp_rdata_q;
    resp_error_d     = resp_error_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          size_d    = req_size;
          signed_d  = req_signed;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata[15:0];
          if (req_err) begin
            resp_rdata_d = 32'h0;
            resp_error_d = 1'b1;
            state_d      = RESP;
          end else if (req_write && req_size == 2'b10) begin
            mem_address_d    = req_addr[ADDR_W+1:2];
            mem_write_data_d = req_wdata;
            state_d          = WRITE;
          end else begin
            mem_address_d = req_addr[ADDR_W+1:2];
            state_d       = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_write_data_d = merged;
          state_d          = WRITE;
        end else begin
          resp_rdata_d = load_val;
          resp_error_d = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      signed_q         <= 1'b0;
      addr_lo_q        <= 2'b00;
      wdata_q          <= 16'h0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'h0;
      resp_rdata_q     <= 32'h0;
      resp_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      addr_lo_q        <= addr_lo_d;
      wdata_q          <= wdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_error_q     <= resp_error_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_address    = mem_address_q;
  assign mem_write_en   = (state_q == WRITE);
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed memory model preloaded word i = i.
module tb_load_store_unit;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wdat;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic        preload_req;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'(i);
    end else if (mem_write_en) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_address];

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req_ready"},      32'(req_ready),      32'h1);
    chk({tag, " resp_valid"},     32'(resp_valid),     32'h0);
    chk({tag, " resp_rdata"},     resp_rdata,          32'h0);
    chk({tag, " resp_error"},     32'(resp_error),     32'h0);
    chk({tag, " mem_write_en"},   32'(mem_write_en),   32'h0);
    chk({tag, " mem_address"},    32'(mem_address),    32'h0);
    chk({tag, " mem_write_data"}, mem_write_data,      32'h0);
  endtask

  // Issues one request, pushes its expectation, waits (bounded) for the response.
  // Returns on the response cycle; if resp_ready is high, steps one more cycle into IDLE.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rd, input logic er,
                         input int nwr, input logic [31:0] wdat);
    exp_t e;
    int n;
    int wr;
    logic [31:0] seen_wd;
    sb.push_back('{rdata: rd, err: er, lat: lat, nwr: nwr, wdat: wdat});
    chk({tag, " req_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; wr = 0; seen_wd = 32'h0;
    forever begin
      if (mem_write_en) begin wr++; seen_wd = mem_write_data; end
      if (resp_valid || n >= 8) break;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'h1);
    chk({tag, " latency"},    32'(n),          32'(e.lat));
    chk({tag, " rdata"},      resp_rdata,      e.rdata);
    chk({tag, " error"},      32'(resp_error), 32'(e.err));
    chk({tag, " write pulses"}, 32'(wr),       32'(e.nwr));
    if (e.nwr > 0) chk({tag, " write data"}, seen_wd, e.wdat);
    if (resp_ready) begin
      @(posedge clk); #1;
      chk({tag, " back to idle"}, 32'(req_ready), 32'h1);
    end
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1; preload_req = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    preload_req = 1'b0;
    chk_reset_outs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_req("ld_w_0x14",   1'b0, 2'b10, 1'b1, 17'h0014, 32'h0, 2, 32'h00000005, 1'b0, 0, 32'h0);
    run_req("st_b_0x09",   1'b1, 2'b00, 1'b0, 17'h0009, 32'h000000AB, 3, 32'h0, 1'b0, 1, 32'h0000AB02);
    run_req("ld_bu_0x09",  1'b0, 2'b00, 1'b0, 17'h0009, 32'h0, 2, 32'h000000AB, 1'b0, 0, 32'h0);
    run_req("ld_bs_0x09",  1'b0, 2'b00, 1'b1, 17'h0009, 32'h0, 2, 32'hFFFFFFAB, 1'b0, 0, 32'h0);
    run_req("st_w_0x10",   1'b1, 2'b10, 1'b0, 17'h0010, 32'h12345678, 2, 32'h0, 1'b0, 1, 32'h12345678);
    run_req("ld_bs_0x13",  1'b0, 2'b00, 1'b1, 17'h0013, 32'h0, 2, 32'h00000012, 1'b0, 0, 32'h0);

    // Fresh memory image so word 2 starts at 2 again.
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    run_req("st_h_0x0A",   1'b1, 2'b01, 1'b0, 17'h000A, 32'h00008001, 3, 32'h0, 1'b0, 1, 32'h80010002);
    run_req("ld_hs_0x0A",  1'b0, 2'b01, 1'b1, 17'h000A, 32'h0, 2, 32'hFFFF8001, 1'b0, 0, 32'h0);
    run_req("ld_hu_0x0A",  1'b0, 2'b01, 1'b0, 17'h000A, 32'h0, 2, 32'h00008001, 1'b0, 0, 32'h0);
    run_req("ld_w_0x08",   1'b0, 2'b10, 1'b0, 17'h0008, 32'h0, 2, 32'h80010002, 1'b0, 0, 32'h0);

    run_req("err_w_0x06",  1'b0, 2'b10, 1'b0, 17'h0006, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
    run_req("err_h_0x03",  1'b0, 2'b01, 1'b0, 17'h0003, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
    run_req("err_sz_st",   1'b1, 2'b11, 1'b0, 17'h0004, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 32'h0);
    chk("err store no write", mem[1], 32'h00000001);

    // Consumer stall: response must hold and no new request may slip in.
    resp_ready = 1'b0;
    run_req("stall_ld",    1'b0, 2'b00, 1'b0, 17'h0005, 32'h0, 2, 32'h00000000, 1'b0, 0, 32'h0);
    held = resp_rdata;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 17'h0014;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall resp_valid", 32'(resp_valid), 32'h1);
      chk("stall rdata",      resp_rdata,      held);
      chk("stall req_ready",  32'(req_ready),  32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("stall release idle",  32'(req_ready),  32'h1);
    chk("stall release valid", 32'(resp_valid), 32'h0);

    // Reset while a byte store sits in READ: no write, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 17'h0004;
    req_wdata = 32'h000000CD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_rd in READ we", 32'(mem_write_en), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("rst_rd");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_rd quiet", {30'h0, mem_write_en, resp_valid}, 32'h0);
    end
    chk("rst_rd mem word1", mem[1], 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
